decode_stage: RTL and testbench

Registered, parametrised RV32I instruction-decode stage with valid/ready handshakes on both sides. Accepts a fetched instruction and its PC, and presents fully decoded fields and a sign-extended immediate one cycle later. All six base formats (R/I/S/B/U/J) are handled, and illegal encodings are flagged. A two-entry skid buffer sustains one instruction per cycle under backpressure. The stage sits between fetch and register-read/execute.

---
 rtl/decode_pkg.sv | 40 ++++
 rtl/decode_stage_field_decode.sv | 81 ++++++++
 rtl/decode_stage.sv | 101 ++++++++++
 tb/tb_decode_stage.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - RV32I opcodes, format enum and decoded-instruction record
package decode_pkg;

  // Record fields are sized for the widest supported XLEN; the stage uses the low XLEN bits.
  localparam int MAX_XLEN = 64;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef struct packed {
    logic [MAX_XLEN-1:0] pc;
    logic [6:0]          opcode;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [MAX_XLEN-1:0] imm;
    fmt_e                fmt;
    logic                rd_we;
    logic                illegal;
  } decoded_t;

endpackage

// File: rtl/decode_stage_field_decode.sv
// rtl/decode_stage_field_decode.sv - combinational RV32I field, format, immediate and legality decode
module rv_field_decode
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  output decoded_t        dec
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       sgn;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];
  assign sgn = instr[31];

  always_comb begin
    dec         = '0;
    dec.pc      = MAX_XLEN'(pc);
    dec.opcode  = opc;
    dec.rd      = instr[11:7];
    dec.rs1     = instr[19:15];
    dec.rs2     = instr[24:20];
    dec.funct3  = f3;
    dec.funct7  = f7;
    dec.fmt     = FMT_R;
    dec.illegal = 1'b0;

    // Every legal opcode ends in 2'b11, so a bad low pair falls into the default arm.
    case (opc)
      OPC_OP: begin
        dec.fmt     = FMT_R;
        dec.illegal = !((f7 == 7'b0000000) ||
                        (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
      end
      OPC_OP_IMM: begin
        dec.fmt = FMT_I;
        if (f3 == 3'b001)      dec.illegal = (f7 != 7'b0000000);
        else if (f3 == 3'b101) dec.illegal = !(f7 == 7'b0000000 || f7 == 7'b0100000);
      end
      OPC_LOAD: begin
        dec.fmt     = FMT_I;
        dec.illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_JALR: begin
        dec.fmt     = FMT_I;
        dec.illegal = (f3 != 3'b000);
      end
      OPC_STORE: begin
        dec.fmt     = FMT_S;
        dec.illegal = (f3 > 3'b010);
      end
      OPC_BRANCH: begin
        dec.fmt     = FMT_B;
        dec.illegal = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OPC_LUI, OPC_AUIPC: dec.fmt = FMT_U;
      OPC_JAL:            dec.fmt = FMT_J;
      default:            dec.illegal = 1'b1;
    endcase

    case (dec.fmt)
      FMT_I:   dec.imm = {{(MAX_XLEN-12){sgn}}, instr[31:20]};
      FMT_S:   dec.imm = {{(MAX_XLEN-12){sgn}}, instr[31:25], instr[11:7]};
      FMT_B:   dec.imm = {{(MAX_XLEN-13){sgn}}, sgn, instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   dec.imm = {{(MAX_XLEN-32){sgn}}, instr[31:12], 12'b0};
      FMT_J:   dec.imm = {{(MAX_XLEN-21){sgn}}, sgn, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: dec.imm = '0;
    endcase

    if (dec.illegal) dec.imm = '0;
    dec.rd_we = !dec.illegal && (dec.rd != 5'd0) &&
                (dec.fmt != FMT_S) && (dec.fmt != FMT_B);
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered RV32I decode stage with two-entry skid buffering
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_rd_we,
  output logic            out_illegal
);

  decoded_t dec;
  decoded_t m_data;
  decoded_t s_data;
  logic     m_valid;
  logic     s_valid;
  logic     accept;
  logic     fire;
  logic     m_free;
  logic     unused_hi;

  rv_field_decode #(.XLEN(XLEN)) u_field_decode (
    .instr (in_instr),
    .pc    (in_pc),
    .dec   (dec)
  );

  // in_ready depends only on the skid flop, so out_ready never reaches it combinationally.
  assign in_ready = !s_valid;
  assign accept   = in_valid && !s_valid;
  assign fire     = m_valid && out_ready;
  assign m_free   = !m_valid || fire;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (m_free) begin
      if (s_valid) begin
        m_valid <= 1'b1;
        s_valid <= accept;
      end else begin
        m_valid <= accept;
      end
    end else if (accept) begin
      s_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_data <= '0;
      s_data <= '0;
    end else if (!flush) begin
      if (m_free) begin
        if (s_valid) begin
          m_data <= s_data;
          if (accept) s_data <= dec;
        end else if (accept) begin
          m_data <= dec;
        end
      end else if (accept) begin
        s_data <= dec;
      end
    end
  end

  assign out_valid   = m_valid;
  assign out_pc      = m_data.pc[XLEN-1:0];
  assign out_opcode  = m_data.opcode;
  assign out_rd      = m_data.rd;
  assign out_rs1     = m_data.rs1;
  assign out_rs2     = m_data.rs2;
  assign out_funct3  = m_data.funct3;
  assign out_funct7  = m_data.funct7;
  assign out_imm     = m_data.imm[XLEN-1:0];
  assign out_fmt     = m_data.fmt;
  assign out_rd_we   = m_data.rd_we;
  assign out_illegal = m_data.illegal;

  // Bits above XLEN are never presented when XLEN is 32.
  assign unused_hi = ^{m_data.imm, m_data.pc};

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage
module tb_decode_stage;

  localparam logic [2:0] F_R = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3, F_U = 3'd4, F_J = 3'd5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_pc, out_imm;
  logic [6:0]  out_opcode, out_funct7;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  out_funct3, out_fmt;
  logic        out_rd_we, out_illegal;

  logic        w_valid = 1'b0;
  logic        w_in_ready;
  logic [31:0] w_instr = 32'h800002B7;
  logic [63:0] w_pc = 64'h8000_0000_0000_0000;
  logic        w_out_valid;
  logic [63:0] w_out_pc, w_out_imm;
  logic [6:0]  w_opcode, w_funct7;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [2:0]  w_funct3, w_fmt;
  logic        w_rd_we, w_illegal;

  decode_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_funct3(out_funct3), .out_funct7(out_funct7), .out_imm(out_imm),
    .out_fmt(out_fmt), .out_rd_we(out_rd_we), .out_illegal(out_illegal)
  );

  decode_stage #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .flush(1'b0),
    .in_valid(w_valid), .in_ready(w_in_ready), .in_instr(w_instr), .in_pc(w_pc),
    .out_valid(w_out_valid), .out_ready(1'b1), .out_pc(w_out_pc),
    .out_opcode(w_opcode), .out_rd(w_rd), .out_rs1(w_rs1), .out_rs2(w_rs2),
    .out_funct3(w_funct3), .out_funct7(w_funct7), .out_imm(w_out_imm),
    .out_fmt(w_fmt), .out_rd_we(w_rd_we), .out_illegal(w_illegal)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        we;
    logic        ill;
  } exp_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } sb_item_t;

  function automatic exp_t model(input logic [31:0] i);
    exp_t       x;
    logic [6:0] op = i[6:0];
    logic [2:0] f3 = i[14:12];
    logic [6:0] f7 = i[31:25];
    x = '0;
    if (op == 7'h33) begin
      x.fmt = F_R;
      x.ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
    end else if (op == 7'h13 || op == 7'h03 || op == 7'h67) begin
      x.fmt = F_I;
      x.imm = {{20{i[31]}}, i[31:20]};
      if (op == 7'h13) x.ill = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
      if (op == 7'h03) x.ill = (f3 == 3'd3) || (f3 >= 3'd6);
      if (op == 7'h67) x.ill = (f3 != 3'd0);
    end else if (op == 7'h23) begin
      x.fmt = F_S;
      x.imm = {{20{i[31]}}, i[31:25], i[11:7]};
      x.ill = (f3 >= 3'd3);
    end else if (op == 7'h63) begin
      x.fmt = F_B;
      x.imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
      x.ill = (f3 == 3'd2) || (f3 == 3'd3);
    end else if (op == 7'h37 || op == 7'h17) begin
      x.fmt = F_U;
      x.imm = {i[31:12], 12'h000};
    end else if (op == 7'h6F) begin
      x.fmt = F_J;
      x.imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
    end else begin
      x.ill = 1'b1;
    end
    if (x.ill) x.imm = '0;
    x.we = !x.ill && (i[11:7] != 5'd0) && (x.fmt != F_S) && (x.fmt != F_B);
    return x;
  endfunction

  sb_item_t sb_q[$];
  sb_item_t sb_it;
  exp_t     sb_e;

  always @(negedge clk) begin
    if (rst || flush) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        check("sb_avail", 64'(sb_q.size() > 0), 64'd1);
        if (sb_q.size() > 0) begin
          sb_it = sb_q.pop_front();
          sb_e  = model(sb_it.instr);
          check("sb_pc", 64'(out_pc), 64'(sb_it.pc));
          check("sb_imm", 64'(out_imm), 64'(sb_e.imm));
          check("sb_fields", 64'({out_opcode, out_rd, out_rs1, out_rs2, out_funct3, out_funct7}),
                64'({sb_it.instr[6:0], sb_it.instr[11:7], sb_it.instr[19:15], sb_it.instr[24:20],
                     sb_it.instr[14:12], sb_it.instr[31:25]}));
          check("sb_ctl", 64'({out_fmt, out_rd_we, out_illegal}), 64'({sb_e.fmt, sb_e.we, sb_e.ill}));
        end
      end
      if (in_valid && in_ready) sb_q.push_back('{instr: in_instr, pc: in_pc});
    end
  end

  logic rand_rdy = 1'b0;
  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] pc);
    logic took = 1'b0;
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
    for (int k = 0; k < 100 && !took; k++) begin
      @(negedge clk);
      took = in_ready;
      step();
    end
    check("send_accept", 64'(took), 64'd1);
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  opcs [9] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
    logic [31:0] r = $urandom;
    int          sel = $urandom_range(0, 10);
    if (sel < 9) r[6:0] = opcs[sel];
    else if (sel == 10) r[1:0] = 2'($urandom_range(0, 2));
    if ($urandom_range(0, 1) == 1) r[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] pc;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_imm", 64'(out_imm), 64'd0);
    check("rst_out_pc", 64'(out_pc), 64'd0);
    step();
    rst = 1'b0;
    step();

    send(32'hFFF00093, 32'h1000);
    @(negedge clk);
    check("addi_valid", 64'(out_valid), 64'd1);
    check("addi_rd", 64'(out_rd), 64'd1);
    check("addi_rs1", 64'(out_rs1), 64'd0);
    check("addi_imm", 64'(out_imm), 64'hFFFFFFFF);
    check("addi_fmt", 64'(out_fmt), 64'(F_I));
    check("addi_we", 64'(out_rd_we), 64'd1);
    check("addi_ill", 64'(out_illegal), 64'd0);
    step();

    send(32'hFE208EE3, 32'h1004);
    @(negedge clk);
    check("beq_rs1", 64'(out_rs1), 64'd1);
    check("beq_rs2", 64'(out_rs2), 64'd2);
    check("beq_imm", 64'(out_imm), 64'hFFFFFFFC);
    check("beq_fmt", 64'(out_fmt), 64'(F_B));
    check("beq_we", 64'(out_rd_we), 64'd0);
    step();

    send(32'h123452B7, 32'h1008);
    @(negedge clk);
    check("lui_imm", 64'(out_imm), 64'h12345000);
    check("lui_rd", 64'(out_rd), 64'd5);
    step();

    send(32'h00000000, 32'h100C);
    @(negedge clk);
    check("zero_ill", 64'(out_illegal), 64'd1);
    check("zero_we", 64'(out_rd_we), 64'd0);
    check("zero_imm", 64'(out_imm), 64'd0);
    step();

    send(32'h40001033, 32'h1010);
    @(negedge clk);
    check("sub_sll_ill", 64'(out_illegal), 64'd1);
    step();

    w_valid = 1'b1;
    step();
    w_valid = 1'b0;
    @(negedge clk);
    check("lui64_valid", 64'(w_out_valid), 64'd1);
    check("lui64_imm", w_out_imm, 64'hFFFFFFFF80000000);
    step();

    // Backpressure: A in M, B in S, C held by the source.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00500113; in_pc = 32'h200;
    step();
    in_instr = 32'h00208133; in_pc = 32'h204;
    step();
    in_instr = 32'h00C00193; in_pc = 32'h208;
    @(negedge clk);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_out_pc", 64'(out_pc), 64'h200);
    check("bp_valid", 64'(out_valid), 64'd1);
    step();
    @(negedge clk);
    check("bp_hold_pc", 64'(out_pc), 64'h200);
    check("bp_hold_imm", 64'(out_imm), 64'd5);
    step();
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_a", 64'(out_pc), 64'h200);
    step();
    @(negedge clk);
    check("bp_b", 64'(out_pc), 64'h204);
    check("bp_b_valid", 64'(out_valid), 64'd1);
    check("bp_in_ready_back", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_c", 64'(out_pc), 64'h208);
    check("bp_c_valid", 64'(out_valid), 64'd1);
    step();

    rand_rdy = 1'b1;
    pc = 32'h4000;
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0) step();
      send(rand_instr(), pc);
      pc += 32'd4;
    end
    rand_rdy = 1'b0;
    step();
    out_ready = 1'b1;
    for (int k = 0; k < 50 && sb_q.size() != 0; k++) step();
    check("drain_empty", 64'(sb_q.size()), 64'd0);

    // Flush with M and S full and an instruction offered.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h300;
    step();
    in_instr = 32'h00200113; in_pc = 32'h304;
    step();
    in_instr = 32'h00300193; in_pc = 32'h308; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_in_ready", 64'(in_ready), 64'd1);
    step();
    @(negedge clk);
    check("fl_lost", 64'(out_valid), 64'd0);
    step();

    // Flush while the offered instruction would otherwise be accepted.
    in_valid = 1'b1; in_instr = 32'h00400213; in_pc = 32'h30C;
    step();
    in_instr = 32'h00500293; in_pc = 32'h310; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("fl2_valid", 64'(out_valid), 64'd0);
    step();
    @(negedge clk);
    check("fl2_lost", 64'(out_valid), 64'd0);
    step();

    // Reset mid-stream.
    in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 32'h400;
    step();
    in_instr = 32'h123452B7; in_pc = 32'h404;
    step();
    in_instr = 32'hFE208EE3; in_pc = 32'h408; rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("rs_valid", 64'(out_valid), 64'd0);
    check("rs_in_ready", 64'(in_ready), 64'd1);
    check("rs_pc", 64'(out_pc), 64'd0);
    check("rs_imm", 64'(out_imm), 64'd0);
    check("rs_rd", 64'(out_rd), 64'd0);
    check("rs_opcode", 64'(out_opcode), 64'd0);
    step();
    @(negedge clk);
    check("rs_lost", 64'(out_valid), 64'd0);
    step();

    out_ready = 1'b1;
    send(32'h00A00513, 32'h500);
    send(32'h00B50593, 32'h504);
    for (int k = 0; k < 20 && sb_q.size() != 0; k++) step();
    check("final_drain", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
